// File: rtl/rom_bus_ctrl_pkg.sv
// Shared types and constants for the Z80 ROM bus controller.
// The optional ROM page register is enabled with `ROM_PAGING_EN.
package rom_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } rom_state_t;

    localparam logic [1:0] ROM_REGION      = 2'b00;
    localparam logic [7:0] PG_PORT_DEFAULT = 8'hF7;
    localparam int         CNT_W           = 4;

    function automatic logic is_rom_addr(input logic [15:0] a);
        return a[15:14] == ROM_REGION;
    endfunction

endpackage

// File: rtl/rom_bus_ctrl_if.sv
// Z80 CPU side and ROM side signals of the ROM bus controller.
// The slave modport is the controller; the master modport is the CPU/ROM environment.
interface rom_bus_ctrl_if;
    logic [15:0] za;
    logic [7:0]  zd_in;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic [15:0] rom_a;
    logic [1:0]  rom_pg;
    logic        rom_ce_n;
    logic [7:0]  rom_d;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic        wait_n;

    modport slave (
        input  za, zd_in, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, rom_d,
        output rom_a, rom_pg, rom_ce_n, zd_out, zd_oe, wait_n
    );

    modport master (
        output za, zd_in, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, rom_d,
        input  rom_a, rom_pg, rom_ce_n, zd_out, zd_oe, wait_n
    );
endinterface

// File: rtl/rom_bus_ctrl_sync2.sv
// Two-flop synchronizer for an active-low Z80 strobe.
// Resets to 1 so a strobe reads as inactive until it has crossed both flops.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/rom_bus_ctrl.sv
// Z80 ROM read sequencer: synchronizes the strobes, enables the ROM for WAIT_CYCLES
// with WAIT asserted, then drives the latched byte until the cycle ends. `ROM_PAGING_EN adds a page register.
//
// state     | meaning
// ST_IDLE   | no ROM cycle, waiting for a synchronized ROM read
// ST_ACCESS | rom_ce_n low, wait_n low, counting down to data capture
// ST_HOLD   | zd_out driven until mreq or rd is released
module rom_bus_ctrl
    import rom_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  PG_PORT     = PG_PORT_DEFAULT
) (
    input logic           fclk,
    input logic           rst,
    rom_bus_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    logic w_mreq_n;
    logic w_rd_n;
    logic w_rfsh_n;

    sync2 u_sync_mreq (.clk(fclk), .rst(rst), .i_d(bus.mreq_n), .o_q(w_mreq_n));
    sync2 u_sync_rd   (.clk(fclk), .rst(rst), .i_d(bus.rd_n),   .o_q(w_rd_n));
    sync2 u_sync_rfsh (.clk(fclk), .rst(rst), .i_d(bus.rfsh_n), .o_q(w_rfsh_n));

    rom_state_t       r_state;
    rom_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [15:0]      r_rom_a;
    logic [15:0]      w_rom_a_nxt;
    logic             r_ce_n;
    logic             w_ce_n_nxt;
    logic [7:0]       r_zd_out;
    logic [7:0]       w_zd_out_nxt;
    logic             r_zd_oe;
    logic             w_zd_oe_nxt;
    logic             r_wait_n;
    logic             w_wait_n_nxt;

    logic w_rom_req;
    logic w_release;

    assign w_rom_req = !w_mreq_n && !w_rd_n && w_rfsh_n && is_rom_addr(bus.za);
    assign w_release = w_mreq_n || w_rd_n;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rom_a  <= 16'h0000;
            r_ce_n   <= 1'b1;
            r_zd_out <= 8'hFF;
            r_zd_oe  <= 1'b0;
            r_wait_n <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rom_a  <= w_rom_a_nxt;
            r_ce_n   <= w_ce_n_nxt;
            r_zd_out <= w_zd_out_nxt;
            r_zd_oe  <= w_zd_oe_nxt;
            r_wait_n <= w_wait_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rom_a_nxt  = r_rom_a;
        w_ce_n_nxt   = r_ce_n;
        w_zd_out_nxt = r_zd_out;
        w_zd_oe_nxt  = r_zd_oe;
        w_wait_n_nxt = r_wait_n;
        case (r_state)
            ST_IDLE: begin
                if (w_rom_req) begin
                    w_state_nxt  = ST_ACCESS;
                    w_rom_a_nxt  = bus.za;
                    w_ce_n_nxt   = 1'b0;
                    w_wait_n_nxt = 1'b0;
                    w_cnt_nxt    = CNT_LOAD;
                end
            end
            ST_ACCESS: begin
                // An abort wins over a capture due in the same cycle; zd_out keeps its old byte.
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_ce_n_nxt   = 1'b1;
                    w_wait_n_nxt = 1'b1;
                    w_zd_oe_nxt  = 1'b0;
                end else if (r_cnt == '0) begin
                    w_state_nxt  = ST_HOLD;
                    w_zd_out_nxt = bus.rom_d;
                    w_ce_n_nxt   = 1'b1;
                    w_zd_oe_nxt  = 1'b1;
                    w_wait_n_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_zd_oe_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_ce_n_nxt   = 1'b1;
                w_zd_oe_nxt  = 1'b0;
                w_wait_n_nxt = 1'b1;
            end
        endcase
    end

    assign bus.rom_a    = r_rom_a;
    assign bus.rom_ce_n = r_ce_n;
    assign bus.zd_out   = r_zd_out;
    assign bus.zd_oe    = r_zd_oe;
    assign bus.wait_n   = r_wait_n;

`ifdef ROM_PAGING_EN
    logic       w_iorq_n;
    logic       w_wr_n;
    logic       w_pg_wr;
    logic       r_pg_wr_d;
    logic [1:0] r_rom_pg;

    sync2 u_sync_iorq (.clk(fclk), .rst(rst), .i_d(bus.iorq_n), .o_q(w_iorq_n));
    sync2 u_sync_wr   (.clk(fclk), .rst(rst), .i_d(bus.wr_n),   .o_q(w_wr_n));

    assign w_pg_wr = !w_iorq_n && !w_wr_n && (bus.za[7:0] == PG_PORT);

    // Load only on the first cycle of the strobe so a long OUT cycle writes once.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_pg_wr_d <= 1'b0;
            r_rom_pg  <= 2'b00;
        end else begin
            r_pg_wr_d <= w_pg_wr;
            if (w_pg_wr && !r_pg_wr_d) begin
                r_rom_pg <= bus.zd_in[1:0];
            end
        end
    end

    assign bus.rom_pg = r_rom_pg;
`else
    assign bus.rom_pg = 2'b00;
`endif

endmodule

// File: doc/rom_bus_ctrl.md
ROM_BUS_CTRL -- requirements
Module: rom_bus_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: fclk cycles rom_ce_n is held low before data capture (legal 1..15).
REQ-002 Parameter PG_PORT, default 8'hF7: low address byte of the ROM page I/O port (used only with ROM_PAGING_EN).
REQ-003 fclk  in  1  single system clock; every flop is clocked on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 za  in  16  Z80 address bus.
REQ-006 zd_in  in  8  Z80 data bus as seen from the CPU (write data).
REQ-007 mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  Z80 strobes, active-low, asynchronous to fclk.
REQ-008 rom_a  out  16  address to the ROM.
REQ-009 rom_pg  out  2  ROM page select.
REQ-010 rom_ce_n  out  1  ROM chip enable, active-low.
REQ-011 rom_d  in  8  ROM data, undefined while rom_ce_n is high.
REQ-012 zd_out  out  8  latched ROM data toward the CPU.
REQ-013 zd_oe  out  1  high while zd_out is to be driven on the CPU bus.
REQ-014 wait_n  out  1  Z80 WAIT, active-low.

Function
REQ-015 The strobes pass through a 2-flop synchronizer; all decoding uses the synchronized copies; za, zd_in are sampled in the same cycle as the synchronized strobe edge.
REQ-016 ROM read request = mreq low, rd low, rfsh high, za[15:14]==2'b00.
REQ-017 FSM states IDLE, ACCESS, HOLD; reset state IDLE.
REQ-018 IDLE->ACCESS on a ROM read request: rom_a<=za, rom_ce_n<=0, wait_n<=0, counter<=WAIT_CYCLES-1.
REQ-019 ACCESS: the counter decrements each cycle; when it is 0, zd_out<=rom_d, rom_ce_n<=1, zd_oe<=1, wait_n<=1, go to HOLD.
REQ-020 HOLD: zd_out and zd_oe stay stable until synchronized mreq or rd goes high, then zd_oe<=0 and go to IDLE in that cycle.
REQ-021 Latency: rom_ce_n falls 1 cycle after the synchronized request; zd_oe rises WAIT_CYCLES cycles after rom_ce_n falls.
REQ-022 Abort: mreq or rd going high during ACCESS -> IDLE next cycle, rom_ce_n=1, wait_n=1, zd_out unchanged, zd_oe stays 0.
REQ-023 Memory writes, refresh cycles and accesses with za[15:14]!=0 never leave IDLE and never touch rom_ce_n.
REQ-024 A new request is accepted only from IDLE; back-to-back reads need the strobes to go high between them.
REQ-025 Only rom_ce_n, zd_oe and wait_n change between requests; rom_a holds its last value in IDLE.

Reset
REQ-026 While rst is high: state=IDLE, rom_a=16'h0000, rom_pg=2'b00, rom_ce_n=1, zd_out=8'hFF, zd_oe=0, wait_n=1, counter=0, synchronizers=1 (inactive).
REQ-027 rst asserted mid-ACCESS or mid-HOLD takes effect immediately (asynchronously); no partial cycle completes after release.
REQ-028 After rst falls, the first request is recognised no earlier than the 2-cycle synchronizer delay.

Configuration
REQ-029 Macro ROM_PAGING_EN: defined -> an I/O write (iorq low, wr low, za[7:0]==PG_PORT) loads rom_pg<=zd_in[1:0] one cycle after the synchronized edge; one load per strobe.
REQ-030 ROM_PAGING_EN undefined -> rom_pg is constant 2'b00, iorq_n and zd_in are unused, and no paging logic exists.
REQ-031 A page write never disturbs an ACCESS or HOLD in progress.

Structure
REQ-032 Shared package rom_bus_pkg holds the FSM state encoding, ROM_REGION (2'b00) and the default PG_PORT constant.
REQ-033 Sub-module sync2 (2-flop synchronizer, async-high reset to 1) is instantiated once per Z80 strobe.

Verification
REQ-034 Read za=16'h0011, ROM returns 8'hF9, WAIT_CYCLES=2 -> rom_ce_n low exactly 2 cycles, zd_out=8'hF9, zd_oe high until rd_n rises, wait_n low for exactly 2 cycles.
REQ-035 Read za=16'h4000 and write za=16'h0005 -> rom_ce_n stays high, zd_oe stays 0, wait_n stays 1.
REQ-036 rd_n released one cycle into ACCESS (WAIT_CYCLES=4) -> IDLE, rom_ce_n=1, zd_oe never rises, zd_out keeps previous value.
REQ-037 rst pulsed during HOLD -> zd_oe=0, zd_out=8'hFF, wait_n=1 asynchronously; a following read of 16'h0000 returns 8'h21.
REQ-038 With ROM_PAGING_EN, OUT (8'hF7),8'h02 then read 16'h0000 -> rom_pg=2'b10 during ACCESS; without the macro rom_pg=2'b00.
REQ-039 Refresh cycle (mreq low, rfsh low, za=16'h0010) -> no ROM access.
